// File: rtl/qracc_output_writeback_if.sv
// Vector input and buffer-write ports of the output writeback unit.
// The master side is the environment (scaler and buffer); the slave side is the writeback unit.
interface qracc_output_writeback_if #(
  parameter int numBanks    = 8,
  parameter int colsPerBank = 32,
  parameter int elementBits = 8,
  parameter int addrWidth   = 32,
  parameter int chanWidth   = 16
);
  localparam int vecWidth   = numBanks * colsPerBank * elementBits;
  localparam int writeWidth = colsPerBank * elementBits;
  localparam int strbWidth  = writeWidth / 8;

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [vecWidth-1:0]   in_data_i;
  logic [addrWidth-1:0]  in_addr_i;
  logic [chanWidth-1:0]  cfg_num_ch_i;
  logic                  cfg_4bit_i;
  logic                  wr_valid_o;
  logic                  wr_ready_i;
  logic [addrWidth-1:0]  wr_addr_o;
  logic [writeWidth-1:0] wr_data_o;
  logic [strbWidth-1:0]  wr_strb_o;

  modport master (
    output in_valid_i, in_data_i, in_addr_i, cfg_num_ch_i, cfg_4bit_i, wr_ready_i,
    input  in_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_addr_i, cfg_num_ch_i, cfg_4bit_i, wr_ready_i,
    output in_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o
  );
endinterface

// File: rtl/qracc_output_writeback.sv
// Output writeback: queues whole scaled output vectors and serialises each one into
// full-width activation-buffer writes with byte strobes (8-bit or packed 4-bit).
module qracc_output_writeback #(
  parameter int numBanks    = 8,
  parameter int colsPerBank = 32,
  parameter int elementBits = 8,
  parameter int queueDepth  = 4,
  parameter int addrWidth   = 32,
  parameter int chanWidth   = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         clear_i,
  qracc_output_writeback_if.slave      bus,
  output logic [$clog2(queueDepth):0]  occupancy_o,
  output logic                         busy_o
);
  localparam int vecWidth   = numBanks * colsPerBank * elementBits;
  localparam int writeWidth = colsPerBank * elementBits;
  localparam int strbWidth  = writeWidth / 8;
  localparam int totalCh    = numBanks * colsPerBank;
  localparam int ptrWidth   = $clog2(queueDepth);
  localparam int occWidth   = ptrWidth + 1;
  localparam int kWidth     = $clog2(numBanks) + 1;
  localparam int vecIdxW    = $clog2(vecWidth);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;

  function automatic logic [7:0] elem_at(input logic [vecWidth-1:0] vec, input logic [31:0] idx);
    logic [vecIdxW-1:0] bit_idx;
    bit_idx = vecIdxW'(idx * 32'(elementBits));
    elem_at = vec[bit_idx +: 8];
  endfunction

  logic [vecWidth-1:0]   data_mem_r [queueDepth];
  logic [addrWidth-1:0]  addr_mem_r [queueDepth];
  logic [chanWidth-1:0]  nch_mem_r  [queueDepth];
  logic [queueDepth-1:0] b4_mem_r;
  logic [ptrWidth-1:0]   wr_ptr_r, rd_ptr_r;
  logic [occWidth-1:0]   occ_r;
  state_t                state_r, state_nx_s;
  logic [kWidth-1:0]     k_r;
  logic                  wr_valid_r;
  logic [addrWidth-1:0]  wr_addr_r;
  logic [writeWidth-1:0] wr_data_r;
  logic [strbWidth-1:0]  wr_strb_r;
  logic                  push_s, pop_s, load_s, hs_s;
  logic [vecWidth-1:0]   head_data_s;
  logic [addrWidth-1:0]  head_addr_s;
  logic [chanWidth-1:0]  head_nch_s;
  logic                  head_b4_s;
  logic [31:0]           head_ch_s, head_nwr_s, sel_k_s;
  logic [addrWidth-1:0]  nx_addr_s;
  logic [writeWidth-1:0] nx_data_s;
  logic [strbWidth-1:0]  nx_strb_s;

  // A full queue never accepts, even when the head is popped in the same cycle.
  assign bus.in_ready_o = (occ_r < occWidth'(queueDepth));
  assign push_s         = bus.in_valid_i & bus.in_ready_o & ~clear_i;
  assign hs_s           = wr_valid_r & bus.wr_ready_i;
  assign bus.wr_valid_o = wr_valid_r;
  assign bus.wr_addr_o  = wr_addr_r;
  assign bus.wr_data_o  = wr_data_r;
  assign bus.wr_strb_o  = wr_strb_r;
  assign occupancy_o    = occ_r;
  assign busy_o         = (occ_r != occWidth'(0)) | wr_valid_r;

  // Vector storage; contents are only read while the entry is counted as occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= bus.in_data_i;
      addr_mem_r[wr_ptr_r] <= bus.in_addr_i;
      nch_mem_r[wr_ptr_r]  <= bus.cfg_num_ch_i;
      b4_mem_r[wr_ptr_r]   <= bus.cfg_4bit_i;
    end
  end

  // Queue pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else if (clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + ptrWidth'(push_s);
      rd_ptr_r <= rd_ptr_r + ptrWidth'(pop_s);
      occ_r    <= occ_r + occWidth'(push_s) - occWidth'(pop_s);
    end
  end

  // Head entry decode: capped channel count and number of writes it needs.
  always_comb begin
    head_data_s = data_mem_r[rd_ptr_r];
    head_addr_s = addr_mem_r[rd_ptr_r];
    head_nch_s  = nch_mem_r[rd_ptr_r];
    head_b4_s   = b4_mem_r[rd_ptr_r];
    if (32'(head_nch_s) > 32'(totalCh)) begin
      head_ch_s = 32'(totalCh);
    end else begin
      head_ch_s = 32'(head_nch_s);
    end
    if (head_b4_s) begin
      head_nwr_s = (head_ch_s + 32'(2 * colsPerBank) - 32'd1) / 32'(2 * colsPerBank);
    end else begin
      head_nwr_s = (head_ch_s + 32'(colsPerBank) - 32'd1) / 32'(colsPerBank);
    end
  end

  // Index of the write being prepared: 0 from LOAD, the following one from DRAIN.
  always_comb begin
    if (state_r == DRAIN) begin
      sel_k_s = 32'(k_r) + 32'd1;
    end else begin
      sel_k_s = 32'd0;
    end
    nx_addr_s = head_addr_s + addrWidth'(sel_k_s * 32'(strbWidth));
  end

  for (genvar b = 0; b < strbWidth; b++) begin : g_byte
    logic [31:0] lo_ch_s, hi_ch_s;
    logic [7:0]  lo_el_s, hi_el_s, byte_s;
    logic        strb_s;

    // One output byte: a single element, or two low nibbles with the even channel low.
    always_comb begin
      byte_s = 8'd0;
      strb_s = 1'b0;
      if (head_b4_s) begin
        lo_ch_s = sel_k_s * 32'(2 * colsPerBank) + 32'(2 * b);
        hi_ch_s = lo_ch_s + 32'd1;
      end else begin
        lo_ch_s = sel_k_s * 32'(colsPerBank) + 32'(b);
        hi_ch_s = 32'hFFFF_FFFF;
      end
      lo_el_s = elem_at(head_data_s, lo_ch_s);
      hi_el_s = elem_at(head_data_s, hi_ch_s);
      if (lo_ch_s < head_ch_s) begin
        strb_s = 1'b1;
        if (head_b4_s) begin
          byte_s[3:0] = lo_el_s[3:0];
        end else begin
          byte_s = lo_el_s;
        end
      end else begin
        strb_s = 1'b0;
      end
      if (head_b4_s && (hi_ch_s < head_ch_s)) begin
        byte_s[7:4] = hi_el_s[3:0];
      end else begin
        byte_s[7:4] = byte_s[7:4];
      end
    end

    assign nx_data_s[8*b +: 8] = byte_s;
    assign nx_strb_s[b]        = strb_s;
  end

  // FSM state register; clear_i abandons any pending write.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else if (clear_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state, write-load and pop decisions.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (occ_r != occWidth'(0)) begin
          state_nx_s = LOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        if (head_nwr_s == 32'd0) begin
          pop_s      = 1'b1;
          state_nx_s = IDLE;
        end else begin
          load_s     = 1'b1;
          state_nx_s = DRAIN;
        end
      end
      DRAIN: begin
        if (hs_s) begin
          if ((32'(k_r) + 32'd1) < head_nwr_s) begin
            load_s     = 1'b1;
            state_nx_s = DRAIN;
          end else begin
            pop_s = 1'b1;
            if ((occ_r > occWidth'(1)) || push_s) begin
              state_nx_s = LOAD;
            end else begin
              state_nx_s = IDLE;
            end
          end
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Write output registers: held stable until accepted, reloaded on the accepting edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      wr_strb_r  <= '0;
      k_r        <= '0;
    end else if (clear_i) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      wr_strb_r  <= '0;
      k_r        <= '0;
    end else if (load_s) begin
      wr_valid_r <= 1'b1;
      wr_addr_r  <= nx_addr_s;
      wr_data_r  <= nx_data_s;
      wr_strb_r  <= nx_strb_s;
      k_r        <= sel_k_s[kWidth-1:0];
    end else if (hs_s) begin
      wr_valid_r <= 1'b0;
    end else begin
      wr_valid_r <= wr_valid_r;
    end
  end
endmodule

// File: tb/tb_qracc_output_writeback.sv
// Bench for qracc_output_writeback: directed cases plus randomized vectors, checked against
// a channel-level reference model of the expected buffer writes.
module tb_qracc_output_writeback;
  localparam int NB = 8;
  localparam int CPB = 32;
  localparam int EB = 8;
  localparam int QD = 4;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int VW = NB * CPB * EB;
  localparam int WW = CPB * EB;
  localparam int SW = WW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic [SW-1:0] strb;
  } wr_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic clear = 1'b0;
  logic [$clog2(QD):0] occupancy;
  logic busy;
  int n_checks = 0;
  int n_fail = 0;
  int n_writes = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];
  bit ready_rand = 1'b0;
  logic ready_val = 1'b1;

  qracc_output_writeback_if #(.numBanks(NB), .colsPerBank(CPB), .elementBits(EB),
                              .addrWidth(AW), .chanWidth(CW)) bus ();

  qracc_output_writeback #(.numBanks(NB), .colsPerBank(CPB), .elementBits(EB), .queueDepth(QD),
                           .addrWidth(AW), .chanWidth(CW)) dut (
    .clk(clk), .nrst(nrst), .clear_i(clear), .bus(bus), .occupancy_o(occupancy), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected writes, built channel by channel from the capped count and the mode.
  function automatic void model_push(input logic [VW-1:0] d, input logic [AW-1:0] a,
                                     input int nch, input bit b4);
    int c, e, n, j;
    logic [10:0] bi;
    logic [7:0] el, di;
    wr_t w;
    c = (nch > NB * CPB) ? NB * CPB : nch;
    e = b4 ? 2 * CPB : CPB;
    n = (c + e - 1) / e;
    for (int k = 0; k < n; k++) begin
      w.addr = a + AW'(k * SW);
      w.data = '0;
      w.strb = '0;
      for (int ch = k * e; ch < (k + 1) * e && ch < c; ch++) begin
        j = ch - k * e;
        bi = 11'(ch * EB);
        el = d[bi +: 8];
        if (b4) begin
          di = 8'(j * 4);
          w.data[di +: 4] = el[3:0];
          w.strb[5'(j / 2)] = 1'b1;
        end else begin
          di = 8'(j * 8);
          w.data[di +: 8] = el;
          w.strb[5'(j)] = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endfunction

  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] r;
    logic [10:0] bi;
    for (int e = 0; e < NB * CPB; e++) begin
      bi = 11'(e * EB);
      r[bi +: 8] = 8'(e);
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    logic [10:0] bi;
    for (int i = 0; i < VW / 32; i++) begin
      bi = 11'(i * 32);
      r[bi +: 32] = $urandom();
    end
    return r;
  endfunction

  // Buffer-side ready driver.
  initial begin
    bus.wr_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) bus.wr_ready_i = 1'($urandom_range(1, 0));
      else bus.wr_ready_i = ready_val;
    end
  end

  // Monitor: scores writes, checks stall stability, feeds accepted vectors to the model.
  initial begin
    logic stall_q;
    logic [AW-1:0] st_addr;
    logic [WW-1:0] st_data;
    logic [SW-1:0] st_strb;
    wr_t w;
    stall_q = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst && !clear) begin
        if (stall_q) begin
          check_eq("stall_valid", 256'(bus.wr_valid_o), 256'(1'b1));
          check_eq("stall_addr_strb", 256'({bus.wr_addr_o, bus.wr_strb_o}), 256'({st_addr, st_strb}));
          check_eq("stall_data", 256'(bus.wr_data_o), 256'(st_data));
        end
        if (bus.wr_valid_o && bus.wr_ready_i) begin
          n_writes++;
          w.addr = bus.wr_addr_o;
          w.data = bus.wr_data_o;
          w.strb = bus.wr_strb_o;
          obs_q.push_back(w);
          if (exp_q.size() == 0) begin
            check_eq("unexpected_write", 256'(w.addr), 256'(32'hDEAD_BEEF));
          end else begin
            w = exp_q.pop_front();
            check_eq("wr_addr", 256'(bus.wr_addr_o), 256'(w.addr));
            check_eq("wr_data", 256'(bus.wr_data_o), 256'(w.data));
            check_eq("wr_strb", 256'(bus.wr_strb_o), 256'(w.strb));
          end
        end
        if (bus.in_valid_i && bus.in_ready_o)
          model_push(bus.in_data_i, bus.in_addr_i, int'(bus.cfg_num_ch_i), bus.cfg_4bit_i);
        stall_q = bus.wr_valid_o && !bus.wr_ready_i;
        st_addr = bus.wr_addr_o;
        st_data = bus.wr_data_o;
        st_strb = bus.wr_strb_o;
      end else begin
        if (clear) exp_q.delete();
        stall_q = 1'b0;
      end
    end
  end

  task automatic push_vec(input logic [VW-1:0] d, input logic [AW-1:0] a, input int nch,
                          input bit b4, input int budget);
    bit acc;
    acc = 1'b0;
    bus.in_data_i = d;
    bus.in_addr_i = a;
    bus.cfg_num_ch_i = CW'(nch);
    bus.cfg_4bit_i = b4;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid_i = 1'b0;
    check_eq("push_accept", 256'(acc), 256'(1'b1));
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_eq("drain_done", 256'(exp_q.size() == 0 && !busy), 256'(1'b1));
  endtask

  task automatic set_ready(input logic v);
    @(negedge clk);
    ready_val = v;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_wr_valid(input string tag);
    int i;
    i = 0;
    while (!bus.wr_valid_o && i < 20) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_eq(tag, 256'(bus.wr_valid_o), 256'(1'b1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] rv;
    logic [WW-1:0] tmp;
    int nw0, nch;
    int nch_tab[14] = '{0, 1, 31, 32, 33, 63, 64, 65, 100, 200, 255, 256, 257, 1000};
    logic [AW-1:0] a;

    bus.in_valid_i = 1'b0;
    bus.in_data_i = '0;
    bus.in_addr_i = '0;
    bus.cfg_num_ch_i = '0;
    bus.cfg_4bit_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 256'(bus.wr_valid_o), 256'(1'b0));
    check_eq("rst_addr_strb", 256'({bus.wr_addr_o, bus.wr_strb_o}), 256'(64'd0));
    check_eq("rst_data", 256'(bus.wr_data_o), 256'd0);
    check_eq("rst_occ_busy", 256'({occupancy, busy}), 256'(4'd0));
    check_eq("rst_in_ready", 256'(bus.in_ready_o), 256'(1'b1));
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // 8-bit, C=64, plus push-to-valid latency
    rv = ramp();
    obs_q.delete();
    push_vec(rv, 32'h100, 64, 1'b0, 20);
    check_eq("lat_t0", 256'(bus.wr_valid_o), 256'(1'b0));
    @(posedge clk); #1;
    check_eq("lat_t1", 256'(bus.wr_valid_o), 256'(1'b0));
    @(posedge clk); #1;
    check_eq("lat_t2", 256'(bus.wr_valid_o), 256'(1'b1));
    wait_idle(100);
    check_eq("t1_count", 256'(obs_q.size()), 256'(2));
    check_eq("t1_addr", 256'({obs_q[0].addr, obs_q[1].addr}), 256'({32'h100, 32'h120}));
    check_eq("t1_byte32", 256'(obs_q[1].data[7:0]), 256'(8'd32));
    check_eq("t1_strb", 256'({obs_q[0].strb, obs_q[1].strb}), 256'(64'hFFFF_FFFF_FFFF_FFFF));

    // 8-bit, C=40
    obs_q.delete();
    push_vec(rv, 32'h100, 40, 1'b0, 20);
    wait_idle(100);
    check_eq("t2_count", 256'(obs_q.size()), 256'(2));
    check_eq("t2_strb", 256'({obs_q[0].strb, obs_q[1].strb}), 256'(64'hFFFF_FFFF_0000_00FF));
    tmp = obs_q[1].data;
    check_eq("t2_data1", 256'(tmp), 256'(64'h2726_2524_2322_2120));

    // 4-bit, C=96
    obs_q.delete();
    push_vec(rv, 32'h100, 96, 1'b1, 20);
    wait_idle(100);
    check_eq("t3_count", 256'(obs_q.size()), 256'(2));
    check_eq("t3_byte0", 256'(obs_q[0].data[7:0]), 256'(8'h10));
    check_eq("t3_addr1", 256'(obs_q[1].addr), 256'(32'h120));
    check_eq("t3_strb", 256'({obs_q[0].strb, obs_q[1].strb}), 256'(64'hFFFF_FFFF_0000_FFFF));

    // Stall mid-drain, fill the queue, fifth vector must wait
    nw0 = n_writes;
    set_ready(1'b0);
    for (int i = 0; i < 4; i++) push_vec(rv, AW'(32'h200 + i * 32'h100), 64, 1'b0, 20);
    @(posedge clk); #1;
    check_eq("t4_full_occ", 256'(occupancy), 256'(3'd4));
    check_eq("t4_head_addr", 256'(bus.wr_addr_o), 256'(32'h200));
    bus.in_data_i = rv;
    bus.in_addr_i = 32'h600;
    bus.cfg_num_ch_i = CW'(64);
    bus.cfg_4bit_i = 1'b0;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_in_ready_low", 256'({bus.in_ready_o, occupancy}), 256'(4'b0100));
    end
    ready_val = 1'b1;
    push_vec(rv, 32'h600, 64, 1'b0, 50);
    wait_idle(200);
    check_eq("t4_writes", 256'(n_writes - nw0), 256'(10));

    // C=0 then C=1000
    obs_q.delete();
    nw0 = n_writes;
    push_vec(rv, 32'h100, 0, 1'b0, 20);
    repeat (4) @(posedge clk);
    #1;
    wait_idle(50);
    check_eq("t5_zero_writes", 256'(n_writes - nw0), 256'(0));
    check_eq("t5_zero_occ", 256'(occupancy), 256'(3'd0));
    push_vec(rv, 32'h100, 1000, 1'b0, 20);
    wait_idle(100);
    check_eq("t5_cap_count", 256'(obs_q.size()), 256'(8));
    check_eq("t5_cap_addr", 256'({obs_q[0].addr, obs_q[7].addr}), 256'({32'h100, 32'h1E0}));

    // clear_i mid-drain, then push coincident with clear
    set_ready(1'b0);
    push_vec(rv, 32'h300, 256, 1'b0, 20);
    wait_wr_valid("t6_clr_pre");
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_eq("t6_clr_state", 256'({bus.wr_valid_o, occupancy, busy}), 256'(5'd0));
    bus.in_valid_i = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.in_valid_i = 1'b0;
    check_eq("t6_clr_push_drop", 256'(occupancy), 256'(3'd0));
    repeat (4) @(posedge clk);
    #1;
    check_eq("t6_clr_quiet", 256'({bus.wr_valid_o, busy}), 256'(2'd0));

    // asynchronous reset mid-drain
    push_vec(rv, 32'h300, 256, 1'b0, 20);
    wait_wr_valid("t6_rst_pre");
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check_eq("t6_rst_state", 256'({bus.wr_valid_o, occupancy, busy}), 256'(5'd0));
    exp_q.delete();
    @(negedge clk);
    #1;
    nrst = 1'b1;
    set_ready(1'b1);

    // Randomized vectors under random backpressure
    ready_rand = 1'b1;
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
      nch = nch_tab[$urandom_range(13, 0)];
      if ($urandom_range(3, 0) == 0) nch = int'($urandom_range(300, 0));
      if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FF80;
      else a = $urandom();
      push_vec(rand_vec(), a, nch, 1'($urandom_range(1, 0)), 2000);
    end
    wait_idle(5000);
    ready_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
